// File: rtl/video_stream_sequencer.sv
// Raster reader for a frame buffer: issues one read per pixel and streams the returned
// pixels as Avalon-ST packets (one packet per frame) through a 2-entry output FIFO.
module video_stream_sequencer #(
   parameter int H_PIXELS = 320,
   parameter int V_LINES  = 240,
   parameter int ADDR_W   = 17,
   parameter int DATA_W   = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [2:0]        mode_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              rd_issue,
   output logic [DATA_W-1:0] src_data,
   output logic              src_valid,
   input  logic              src_ready,
   output logic              src_sop,
   output logic              src_eop,
   output logic [2:0]        mode_active,
   output logic              frame_done
);

   localparam int COL_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
   localparam int ROW_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_PIXELS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_LINES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic              infl, infl_sop, infl_eop;
   logic [DATA_W-1:0] fifo_data [2];
   logic [1:0]        fifo_sop, fifo_eop;
   logic              wr_ptr, rd_ptr;
   logic [1:0]        count;
   logic              pop, first_px, last_px;

   assign first_px  = (col == '0) && (row == '0);
   assign last_px   = (col == COL_LAST) && (row == ROW_LAST);
   assign src_valid = (count != 2'd0);
   assign pop       = src_valid & src_ready;
   assign src_data  = fifo_data[rd_ptr];
   assign src_sop   = src_valid & fifo_sop[rd_ptr];
   assign src_eop   = src_valid & fifo_eop[rd_ptr];

   // Crediting this cycle's pop lets a read issue every clock without ever
   // committing more than two pixels to the FIFO, whatever src_ready does next.
   assign rd_issue = (state == RUN) &&
                     (({1'b0, count} + {2'b00, infl} - {2'b00, pop}) < 3'd2);

   // NOTE: every register below is updated with non-blocking assignments so all
   // of them sample the pre-edge values of one another, exactly like the flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         col         <= '0;
         row         <= '0;
         rd_addr     <= '0;
         infl        <= 1'b0;
         infl_sop    <= 1'b0;
         infl_eop    <= 1'b0;
         // NOTE: the two FIFO slots are reset only because src_data must read
         // zero out of reset; a deeper buffer would gate the output instead.
         fifo_data   <= '{default: '0};
         fifo_sop    <= '0;
         fifo_eop    <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
         mode_active <= 3'd0;
         frame_done  <= 1'b0;
      end else begin
         if (rd_issue) begin
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
               col <= col + COL_W'(1);
            end
            rd_addr <= last_px ? '0 : rd_addr + ADDR_W'(1);
         end

         infl     <= rd_issue;
         infl_sop <= rd_issue & first_px;
         infl_eop <= rd_issue & last_px;

         if (infl) begin
            fifo_data[wr_ptr] <= rd_data;
            fifo_sop[wr_ptr]  <= infl_sop;
            fifo_eop[wr_ptr]  <= infl_eop;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, infl} - {1'b0, pop};

         frame_done <= pop & src_eop;
         if (pop & src_sop)
            mode_active <= mode_req;

         case (state)
            IDLE:    if (enable) state <= RUN;
            RUN:     if (rd_issue && last_px && !enable) state <= DRAIN;
            DRAIN:   if ((count == 2'd0) && !infl) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
